// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 8-digit seven-segment scan controller.
// Holds an 8-entry BCD buffer, time-slices the anodes with a blanking gap at
// the start of every slot, and can rotate the displayed window once per frame.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | scan stopped (enable low), display dark, counters frozen
// BLANK | first BLANK_CYC cycles of a slot, all anodes off
// DRIVE | remainder of the slot, anode digit_idx on with its digit
//
// seg/an/frame_tick are flopped from the next-cycle values of state, slot,
// offset and buffer, so they change on the same edge as those registers and
// never show a stale anode next to a new digit_idx.
module seven_seg_scan_ctrl #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       scroll_en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ack,
    output logic [6:0] seg,
    output logic [7:0] an,
    output logic [2:0] digit_idx,
    output logic       frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [2:0]    off_q, off_d;
    logic [3:0]    buf_q [8];
    logic [3:0]    buf_d [8];
    logic [2:0]    sel_d;
    logic          wrap;
    logic          frame_d;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h58;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign digit_idx = idx_q;

    // Next-state: prescaler, slot index, scroll offset and FSM transitions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        wrap    = 1'b0;
        frame_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // restart the slot from the top, prescaler already at 0
                    state_d = BLANK;
                end
                BLANK, DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        wrap    = 1'b1;
                        idx_d   = idx_q + 3'd1;
                        state_d = BLANK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (state_q == BLANK && cnt_q == BLANK_LAST) begin
                            state_d = DRIVE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        frame_d = wrap && (idx_q == 3'd7);
        if (frame_d && scroll_en) begin
            off_d = off_q + 3'd1;
        end
    end

    // Buffer write path plus registered display image for the next cycle.
    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[wr_addr] = wr_data;
        end
        sel_d = idx_d + off_d;
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        if (state_d == DRIVE) begin
            an_d  = ~(8'h01 << idx_d);
            seg_d = seg_decode(buf_d[sel_d]);
        end
    end

    // Control state, buffer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            off_q      <= '0;
            buf_q      <= '{default: 4'hF};
            wr_ack     <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 8'hFF;
            seg        <= 7'h7F;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            off_q      <= off_d;
            buf_q      <= buf_d;
            wr_ack     <= wr_en;
            frame_tick <= frame_d;
            an         <= an_d;
            seg        <= seg_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
// A cycle model pushes the expected outputs after every rising edge; a monitor
// pops and compares them on the falling edge. Directed checks cover the
// named scenarios.
module tb_seven_seg_scan_ctrl;

    localparam int SCAN_DIV  = 8;
    localparam int BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       scroll_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_ack;
    logic [6:0] seg;
    logic [7:0] an;
    logic [2:0] digit_idx;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    seven_seg_scan_ctrl #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .scroll_en (scroll_en),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
        logic [2:0] idx;
        logic       frame;
        logic       ack;
    } exp_t;

    exp_t sb[$];

    logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
                                 7'h00, 7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

    logic [3:0] m_buf [8];
    bit         m_run;
    int         m_phase;
    logic [2:0] m_idx;
    logic [2:0] m_off;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_buf[i] = 4'hF;
        m_run   = 1'b0;
        m_phase = 0;
        m_idx   = 3'd0;
        m_off   = 3'd0;
    endtask

    task automatic model_step();
        exp_t       e;
        logic [2:0] pos;
        bit         driving;
        e.ack   = wr_en;
        e.frame = 1'b0;
        if (wr_en) m_buf[wr_addr] = wr_data;
        if (!enable) begin
            m_run   = 1'b0;
            m_phase = 0;
        end else if (!m_run) begin
            m_run   = 1'b1;
            m_phase = 0;
        end else begin
            m_phase++;
            if (m_phase == SCAN_DIV) begin
                m_phase = 0;
                if (m_idx == 3'd7) begin
                    e.frame = 1'b1;
                    if (scroll_en) m_off = m_off + 3'd1;
                end
                m_idx = m_idx + 3'd1;
            end
        end
        driving = m_run && (m_phase >= BLANK_CYC);
        pos     = m_idx + m_off;
        e.idx   = m_idx;
        e.an    = driving ? ~(8'h01 << m_idx) : 8'hFF;
        e.seg   = driving ? dec_tab[m_buf[pos]] : 7'h7F;
        sb.push_back(e);
    endtask

    // reference model, advanced on every rising edge, reset asynchronously
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
                sb.delete();
            end else begin
                model_step();
            end
        end
    end

    // scoreboard compare on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                check_val("sb_an", 32'(an), 32'(e.an));
                check_val("sb_seg", 32'(seg), 32'(e.seg));
                check_val("sb_idx", 32'(digit_idx), 32'(e.idx));
                check_val("sb_frame", 32'(frame_tick), 32'(e.frame));
                check_val("sb_ack", 32'(wr_ack), 32'(e.ack));
            end
        end
    end

    // global time limit
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic wait_drive(input logic [2:0] k);
        int  t;
        bit  found;
        t     = 0;
        found = 1'b0;
        while (!found && t < 400) begin
            @(negedge clk);
            t++;
            if (digit_idx == k && an != 8'hFF) found = 1'b1;
        end
        if (!found) check_val("wait_drive_timeout", 32'(t), 32'(0));
    endtask

    task automatic wait_frame();
        int t;
        bit found;
        t     = 0;
        found = 1'b0;
        while (!found && t < 400) begin
            @(negedge clk);
            t++;
            if (frame_tick) found = 1'b1;
        end
        if (!found) check_val("wait_frame_timeout", 32'(t), 32'(0));
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [3:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int         acks;
        int         ticks;
        logic [3:0] wvals [4];
        wvals = '{4'd1, 4'd9, 4'd9, 4'd0};

        rst       = 1'b0;
        enable    = 1'b0;
        scroll_en = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 3'd0;
        wr_data   = 4'd0;

        // reset values
        repeat (3) @(negedge clk);
        check_val("rst_an", 32'(an), 32'h00FF);
        check_val("rst_seg", 32'(seg), 32'h007F);
        check_val("rst_idx", 32'(digit_idx), 32'd0);
        check_val("rst_frame", 32'(frame_tick), 32'd0);
        check_val("rst_ack", 32'(wr_ack), 32'd0);
        rst = 1'b1;

        // blank buffer scan: two dark cycles, then AN0 with blank code
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check_val("blank0_an", 32'(an), 32'h00FF);
        @(negedge clk);
        check_val("blank1_an", 32'(an), 32'h00FF);
        @(negedge clk);
        check_val("drive0_an", 32'(an), 32'h00FE);
        check_val("drive0_seg", 32'(seg), 32'h007F);
        repeat (6) @(negedge clk);
        check_val("step_idx1", 32'(digit_idx), 32'd1);
        for (int k = 2; k < 8; k++) begin
            repeat (8) @(negedge clk);
            check_val("step_idx", 32'(digit_idx), 32'(k));
        end
        repeat (8) @(negedge clk);
        check_val("wrap_idx0", 32'(digit_idx), 32'd0);
        check_val("wrap_frame", 32'(frame_tick), 32'd1);

        // back-to-back writes while idle, then scan them out
        enable = 1'b0;
        acks   = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_ack) acks++;
            wr_en   = 1'b1;
            wr_addr = 3'(i);
            wr_data = wvals[i];
        end
        @(negedge clk);
        if (wr_ack) acks++;
        wr_en = 1'b0;
        @(negedge clk);
        if (wr_ack) acks++;
        check_val("ack_count", 32'(acks), 32'd4);
        enable = 1'b1;
        wait_drive(3'd0);
        check_val("slot0_seg", 32'(seg), 32'h0079);
        wait_drive(3'd1);
        check_val("slot1_seg", 32'(seg), 32'h0010);
        wait_drive(3'd2);
        check_val("slot2_seg", 32'(seg), 32'h0010);
        wait_drive(3'd3);
        check_val("slot3_seg", 32'(seg), 32'h0040);

        // live write into the slot being driven
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = 3'd3;
        wr_data = 4'd7;
        @(negedge clk);
        wr_en = 1'b0;
        check_val("live_seg", 32'(seg), 32'h0058);
        check_val("live_an", 32'(an), 32'h00F7);

        // frame rate over two frames of continuous scan
        ticks = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (frame_tick) ticks++;
        end
        check_val("frame_count", 32'(ticks), 32'd2);

        // pause in the middle of slot 3
        wait_drive(3'd3);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check_val("pause_an", 32'(an), 32'h00FF);
        check_val("pause_idx", 32'(digit_idx), 32'd3);
        check_val("pause_frame", 32'(frame_tick), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check_val("resume_blank0", 32'(an), 32'h00FF);
        @(negedge clk);
        check_val("resume_blank1", 32'(an), 32'h00FF);
        @(negedge clk);
        check_val("resume_an3", 32'(an), 32'h00F7);
        check_val("resume_idx", 32'(digit_idx), 32'd3);

        // scrolling window with a single visible digit
        enable = 1'b0;
        pulse_reset();
        write_entry(3'd0, 4'd5);
        scroll_en = 1'b1;
        enable    = 1'b1;
        wait_drive(3'd0);
        check_val("scroll0_an0", 32'(seg), 32'h0012);
        wait_frame();
        wait_drive(3'd0);
        check_val("scroll1_an0", 32'(seg), 32'h007F);
        wait_drive(3'd7);
        check_val("scroll1_an7", 32'(seg), 32'h0012);
        wait_frame();
        scroll_en = 1'b0;
        wait_drive(3'd6);
        check_val("scroll2_an6", 32'(seg), 32'h0012);

        // async reset mid-slot and mid-write with offset 2
        wait_drive(3'd5);
        check_val("pre_rst_an", 32'(an), 32'h00DF);
        wr_en   = 1'b1;
        wr_addr = 3'd5;
        wr_data = 4'd2;
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_an", 32'(an), 32'h00FF);
        check_val("arst_seg", 32'(seg), 32'h007F);
        check_val("arst_idx", 32'(digit_idx), 32'd0);
        check_val("arst_ack", 32'(wr_ack), 32'd0);
        check_val("arst_frame", 32'(frame_tick), 32'd0);
        repeat (3) @(negedge clk);
        wr_en = 1'b0;
        rst   = 1'b1;
        write_entry(3'd0, 4'd8);
        enable = 1'b1;
        wait_drive(3'd0);
        check_val("post_rst_slot0", 32'(seg), 32'h0000);
        wait_drive(3'd5);
        check_val("post_rst_slot5", 32'(seg), 32'h007F);
        repeat (70) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12500, meaning clk cycles per digit slot (legal: SCAN_DIV >= 4).
REQ-002 SHALL have parameter BLANK_CYC, default 16, meaning all-off cycles at the start of each slot (legal: 1 <= BLANK_CYC < SCAN_DIV).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  scan run; low = display dark and scan frozen.
REQ-006 SHALL have port scroll_en  input  1  rotate displayed window one position per frame.
REQ-007 SHALL have port wr_en  input  1  write strobe into digit buffer.
REQ-008 SHALL have port wr_addr  input  3  buffer entry, 0 = AN0 position.
REQ-009 SHALL have port wr_data  input  4  BCD code; 10-15 = blank.
REQ-010 SHALL have port wr_ack  output  1  one-cycle write acknowledge.
REQ-011 SHALL have port seg  output  7  active-low segments, bit order {CG,CF,CE,CD,CC,CB,CA}.
REQ-012 SHALL have port an  output  8  active-low anodes, bit i = ANi.
REQ-013 SHALL have port digit_idx  output  3  current scan slot.
REQ-014 SHALL have port frame_tick  output  1  one-cycle pulse at end of slot 7.

Function
REQ-015 SHALL hold an 8 x 4-bit digit buffer; a write with wr_en=1 at edge k stores wr_data into entry wr_addr at edge k, and wr_ack SHALL be 1 for exactly the cycle after edge k.
REQ-016 SHALL accept every write (no back-pressure); back-to-back writes each get their own wr_ack pulse.
REQ-017 SHALL run a prescaler 0..SCAN_DIV-1 while enable=1; at count SCAN_DIV-1 it wraps to 0 and digit_idx increments mod 8 (7 -> 0).
REQ-018 SHALL implement FSM states IDLE, BLANK, DRIVE: IDLE -> BLANK when enable=1; BLANK -> DRIVE when prescaler = BLANK_CYC-1; DRIVE -> BLANK at prescaler wrap; any state -> IDLE when enable=0.
REQ-019 In IDLE and BLANK, an SHALL be 8'hFF and seg 7'h7F.
REQ-020 In DRIVE, an SHALL have only bit digit_idx low and seg SHALL be the decode of buffer[(digit_idx + offset) mod 8].
REQ-021 Decode (hex, seg): 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->58, 8->00, 9->10, 10..15->7F.
REQ-022 seg and an SHALL be registered: they reflect state/buffer/offset values one cycle after those change.
REQ-023 A write to the entry currently driven SHALL appear on seg in the cycle after the write edge with no anode glitch.
REQ-024 frame_tick SHALL pulse for one cycle coincident with the 7 -> 0 wrap of digit_idx; never while enable=0.
REQ-025 A 3-bit offset SHALL increment mod 8 on each frame_tick when scroll_en=1, and hold when scroll_en=0.
REQ-026 enable=0 SHALL hold prescaler at 0 and freeze digit_idx and offset; on re-enable the slot SHALL restart at BLANK with prescaler 0 at the same digit_idx.
REQ-027 Writes SHALL be accepted in every state, including IDLE.

Reset
REQ-028 While rst=0: buffer entries = 4'hF, prescaler = 0, digit_idx = 0, offset = 0, state = IDLE, an = 8'hFF, seg = 7'h7F, wr_ack = 0, frame_tick = 0.
REQ-029 rst asserted mid-slot or mid-write SHALL force reset values immediately (asynchronously); a write coincident with the releasing edge is not required to land.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-030 Reset then enable=1, no writes -> an stays 8'hFF throughout BLANK, then AN0 low with seg 7'h7F (blank code) in DRIVE; digit_idx steps 0..7 every 8 cycles.
REQ-031 Write 1,9,9,0 to addr 0..3, enable=1 -> slot 0 drives seg 7'h79, slot 1 7'h10, slot 2 7'h10, slot 3 7'h40; wr_ack pulses once per write.
REQ-032 Continuous scan -> frame_tick pulses once per 64 cycles, exactly at 7 -> 0 wrap; an never has two bits low and is 8'hFF for 2 cycles at each slot start.
REQ-033 scroll_en=1 with addr0=5, others blank -> digit 5 (seg 7'h12) appears at AN0, then AN7, AN6, ... in successive frames.
REQ-034 Drop enable in DRIVE of slot 3 for 20 cycles -> an 8'hFF, digit_idx holds 3; on re-enable 2 BLANK cycles then AN3 driven.
REQ-035 Assert rst during DRIVE of slot 5 with scroll offset 2 -> an 8'hFF, seg 7'h7F, digit_idx 0, offset 0, buffer all blank immediately.
